rx_serial_8p1: RTL and testbench
================================

Name: rx_serial_8p1

Overview:
- Asynchronous serial receiver for 8 data bits, 1 parity bit and 1 stop bit (8E1 by default, 8O1 selectable).
- Sits directly upstream of the 16-bit word receiver control unit.
- Delivers one byte per frame with a one-cycle `fim_receber` pulse and a `parity_ok` verdict.
- The control unit uses these to decide between loading the byte and going to error.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be >= 4.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- RX  in  1  serial line; idles high; LSB-first data
- dados  out  8  last received byte
- fim_receber  out  1  one-cycle pulse at end of each frame
- parity_ok  out  1  1 = parity correct AND stop bit high; valid while fim_receber=1, held until next fim_receber
- erro_frame  out  1  stop bit sampled low; same timing as parity_ok
- ocupado  out  1  high from confirmed start bit until the fim_receber cycle inclusive
- db_estado  out  4  current state encoding (debug)

Behaviour:
- Reset (synchronous):
  - state = INICIAL; synchronizer flops = 1; counters = 0.
  - dados = 0x00; fim_receber = 0; parity_ok = 0; erro_frame = 0; ocupado = 0.
- Input sync: RX passes through 2 flops to give rx_s. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2 (integer division).
- Baud counter: cleared on every state change; increments every cycle otherwise.
- States:
  - INICIAL: wait for rx_s=0 → CONFIRMA_START.
  - CONFIRMA_START: at count HALF-1, sample rx_s.
    - If 1 (glitch) → INICIAL.
    - If 0 → DADOS with bit index 0.
  - DADOS: at count CLKS_PER_BIT-1, shift rx_s into shift register MSB end (LSB-first line order) and increment index. After the 8th sample → PARIDADE.
  - PARIDADE: at count CLKS_PER_BIT-1, latch the parity bit → STOP.
  - STOP: at count CLKS_PER_BIT-1, sample the stop bit → FIM.
  - FIM (1 cycle):
    - fim_receber = 1.
    - dados = shift register.
    - erro_frame = ~stop.
    - parity_ok = (XOR of 8 data bits ^ parity bit == PARITY_ODD) & stop.
    - If stop was 1 → INICIAL; else → ESPERA_ALTO.
  - ESPERA_ALTO: wait for rx_s=1 → INICIAL. Prevents a break condition from being read as a new start bit.
- Latency: fim_receber is high exactly HALF + 10·CLKS_PER_BIT + 1 clocks after the first cycle with rx_s=0.
- Outputs:
  - dados, parity_ok and erro_frame change only in the FIM cycle (or on reset).
  - fim_receber is never high for 2 consecutive cycles.
- Back-to-back frames: a start edge immediately after a valid stop bit is detected (INICIAL is re-entered the cycle after FIM). No minimum idle time is required.
- Reset mid-frame: aborts with no fim_receber pulse; dados returns to 0.
- RX glitch shorter than HALF cycles: ignored; no outputs change.
- db_estado encoding: INICIAL=0, CONFIRMA_START=1, DADOS=2, PARIDADE=3, STOP=4, FIM=5, ESPERA_ALTO=6. All other codes → INICIAL.

Decomposition:
- State encodings go in the shared serial definitions include.
- Defaults for CLKS_PER_BIT and parity mode also go in that include, shared with the future transmitter.
- One sub-module: contador_baud. It is a modulo counter with synchronous clear and enable, and outputs meio (count==HALF-1) and fim (count==CLKS_PER_BIT-1).
- The FSM and the shift register stay in the top.

Test Plan (CLKS_PER_BIT=16):
- Even parity, byte 0xA5 (parity bit 0, stop 1) → one fim_receber pulse; dados=0xA5; parity_ok=1; erro_frame=0; pulse exactly 169 clocks after rx_s falls.
- Byte 0x3C with wrong parity bit 1 → dados=0x3C, parity_ok=0, erro_frame=0. Connected to the 16-bit control unit, the unit enters ERRO.
- Byte 0x01, correct parity, stop bit 0 held low for 40 bit times → parity_ok=0, erro_frame=1. No second pulse until RX returns high and a new frame is sent.
- RX low pulse of 5 clocks while idle → no fim_receber, ocupado stays 0, db_estado returns to 0.
- Two back-to-back frames 0x34 then 0x12 with zero idle → two pulses, dados=0x34 then 0x12, both parity_ok=1.
- Reset asserted mid data bit 4 of a frame → next cycle db_estado=0, dados=0x00, no fim_receber. The next complete frame 0xFF is received correctly.

Source files
------------

// File: rtl/rx_serial_8p1_pkg.sv
// rtl/rx_serial_8p1_pkg.sv - shared serial definitions: state encodings, line defaults, parity helper
package rx_serial_8p1_pkg;

    // Line defaults shared by the receiver and the future transmitter
    localparam int DEFAULT_CLKS_PER_BIT = 5208;   // 50 MHz / 9600 baud
    localparam bit DEFAULT_PARITY_ODD   = 1'b0;   // even parity

    // Receiver states; the encoding is visible on db_estado
    typedef enum logic [3:0] {
        ST_INICIAL        = 4'd0,
        ST_CONFIRMA_START = 4'd1,
        ST_DADOS          = 4'd2,
        ST_PARIDADE       = 4'd3,
        ST_STOP           = 4'd4,
        ST_FIM            = 4'd5,
        ST_ESPERA_ALTO    = 4'd6
    } state_t;

    // A frame is good only when the parity matches the selected mode and the stop bit is high
    function automatic logic parity_check(input logic [7:0] data, input logic par,
                                          input logic stop, input logic odd);
        return (((^data) ^ par) == odd) && stop;
    endfunction

endpackage

// File: rtl/rx_serial_8p1_contador_baud.sv
// rtl/rx_serial_8p1_contador_baud.sv - modulo-CLKS_PER_BIT baud counter with mid-bit and end-of-bit ticks
module rx_serial_8p1_contador_baud
    import rx_serial_8p1_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic meio,
    output logic fim
);

    localparam int            W    = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0]  LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0]  MID  = W'(CLKS_PER_BIT / 2 - 1);

    logic [W-1:0] count_q, count_d;

    // Clear wins over enable; the count wraps after the last cycle of a bit
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign meio = (count_q == MID);
    assign fim  = (count_q == LAST);

endmodule

// File: rtl/rx_serial_8p1.sv
// rtl/rx_serial_8p1.sv - 8-data/1-parity/1-stop asynchronous serial receiver
module rx_serial_8p1
    import rx_serial_8p1_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit PARITY_ODD   = DEFAULT_PARITY_ODD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] dados,
    output logic       fim_receber,
    output logic       parity_ok,
    output logic       erro_frame,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    state_t     state_q, state_d;
    logic       rx_meta_q, rx_s_q;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_bit_q, parity_bit_d;
    logic [7:0] dados_q, dados_d;
    logic       parity_ok_q, parity_ok_d;
    logic       erro_frame_q, erro_frame_d;
    logic       baud_clear, baud_meio, baud_fim;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Every state change restarts bit timing
    assign baud_clear = (state_d != state_q);

    rx_serial_8p1_contador_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_contador_baud (
        .clock (clock),
        .reset (reset),
        .clear (baud_clear),
        .enable(1'b1),
        .meio  (baud_meio),
        .fim   (baud_fim)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_INICIAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = ST_INICIAL;
        case (state_q)
            ST_INICIAL:        state_d = rx_s_q ? ST_INICIAL : ST_CONFIRMA_START;
            ST_CONFIRMA_START: begin
                if (baud_meio) begin
                    state_d = rx_s_q ? ST_INICIAL : ST_DADOS;
                end else begin
                    state_d = ST_CONFIRMA_START;
                end
            end
            ST_DADOS:          state_d = (baud_fim && idx_q == 3'd7) ? ST_PARIDADE : ST_DADOS;
            ST_PARIDADE:       state_d = baud_fim ? ST_STOP : ST_PARIDADE;
            ST_STOP:           state_d = baud_fim ? ST_FIM : ST_STOP;
            // A low stop bit may be a break; wait for the line to recover first
            ST_FIM:            state_d = erro_frame_q ? ST_ESPERA_ALTO : ST_INICIAL;
            ST_ESPERA_ALTO:    state_d = rx_s_q ? ST_INICIAL : ST_ESPERA_ALTO;
            default:           state_d = ST_INICIAL;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        fim_receber = (state_q == ST_FIM);
        ocupado     = (state_q == ST_DADOS) || (state_q == ST_PARIDADE) ||
                      (state_q == ST_STOP)  || (state_q == ST_FIM);
        db_estado   = state_q;
    end

    // Datapath: result registers load on the STOP->FIM edge so they are valid during the pulse
    always_comb begin
        idx_d        = idx_q;
        shift_d      = shift_q;
        parity_bit_d = parity_bit_q;
        dados_d      = dados_q;
        parity_ok_d  = parity_ok_q;
        erro_frame_d = erro_frame_q;
        case (state_q)
            ST_CONFIRMA_START: idx_d = 3'd0;
            ST_DADOS: begin
                if (baud_fim) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                end
            end
            ST_PARIDADE: begin
                if (baud_fim) begin
                    parity_bit_d = rx_s_q;
                end
            end
            ST_STOP: begin
                if (baud_fim) begin
                    dados_d      = shift_q;
                    erro_frame_d = ~rx_s_q;
                    parity_ok_d  = parity_check(shift_q, parity_bit_q, rx_s_q, PARITY_ODD);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            parity_bit_q <= 1'b0;
            dados_q      <= 8'h00;
            parity_ok_q  <= 1'b0;
            erro_frame_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            parity_bit_q <= parity_bit_d;
            dados_q      <= dados_d;
            parity_ok_q  <= parity_ok_d;
            erro_frame_q <= erro_frame_d;
        end
    end

    assign dados      = dados_q;
    assign parity_ok  = parity_ok_q;
    assign erro_frame = erro_frame_q;

endmodule

// File: tb/tb_rx_serial_8p1.sv
// tb/tb_rx_serial_8p1.sv - self-checking bench for rx_serial_8p1
module tb_rx_serial_8p1;

    localparam int C    = 16;
    localparam int HALF = C / 2;
    // Pulse latency from the RX pin: two synchronizer stages plus the receive latency from rx_s
    localparam int LAT  = 2 + HALF + 10 * C + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       RX;
    logic [7:0] dados;
    logic       fim_receber;
    logic       parity_ok;
    logic       erro_frame;
    logic       ocupado;
    logic [3:0] db_estado;

    rx_serial_8p1 #(
        .CLKS_PER_BIT(C),
        .PARITY_ODD  (1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .RX         (RX),
        .dados      (dados),
        .fim_receber(fim_receber),
        .parity_ok  (parity_ok),
        .erro_frame (erro_frame),
        .ocupado    (ocupado),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] dados;
        logic       parity_ok;
        logic       erro_frame;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc        = 0;
    int  n_checks   = 0;
    int  n_fail     = 0;
    int  double_fim = 0;
    bit  fim_prev   = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: capture every pulse with its cycle stamp, flag back-to-back pulses
    always @(negedge clock) begin
        if (fim_receber) obs_q.push_back(ev_t'{dados, parity_ok, erro_frame, cyc});
        if (fim_receber && fim_prev) double_fim <= double_fim + 1;
        fim_prev <= fim_receber;
    end

    task automatic drive_bits(input logic b, input int nbits);
        RX = b;
        repeat (nbits * C) @(negedge clock);
    endtask

    // Drive one frame starting at a negedge; the expected result is pushed as the start bit goes out
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int stop_bits, input logic exp_ok);
        ev_t e;
        e.dados      = d;
        e.parity_ok  = exp_ok;
        e.erro_frame = ~stop;
        e.cyc        = cyc + LAT;
        exp_q.push_back(e);
        drive_bits(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bits(d[i], 1);
        drive_bits(par, 1);
        drive_bits(stop, stop_bits);
    endtask

    task automatic test_reset();
        RX    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (dados !== 8'h00)     begin n_fail++; $display("FAIL reset_dados: got %h want 00", dados); end
        n_checks++; if (fim_receber !== 1'b0) begin n_fail++; $display("FAIL reset_fim: got %b want 0", fim_receber); end
        n_checks++; if (parity_ok !== 1'b0)  begin n_fail++; $display("FAIL reset_parity_ok: got %b want 0", parity_ok); end
        n_checks++; if (erro_frame !== 1'b0) begin n_fail++; $display("FAIL reset_erro: got %b want 0", erro_frame); end
        n_checks++; if (ocupado !== 1'b0)    begin n_fail++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
        n_checks++; if (db_estado !== 4'd0)  begin n_fail++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
        reset = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_even_parity();
        ev_t o, e;
        send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b1);
        repeat (2 * C) @(negedge clock);
        n_checks++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL even_count: got %0d pulses want 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL even_frame: got d=%h ok=%b err=%b cyc=%0d want d=%h ok=%b err=%b cyc=%0d", o.dados, o.parity_ok, o.erro_frame, o.cyc, e.dados, e.parity_ok, e.erro_frame, e.cyc); end
        end
        n_checks++;
        if (parity_ok !== 1'b1 || dados !== 8'hA5) begin n_fail++; $display("FAIL even_hold: got d=%h ok=%b want d=a5 ok=1", dados, parity_ok); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bad_parity();
        ev_t o, e;
        send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b0);
        repeat (2 * C) @(negedge clock);
        n_checks++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL badpar_count: got %0d pulses want 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL badpar_frame: got d=%h ok=%b err=%b cyc=%0d want d=%h ok=%b err=%b cyc=%0d", o.dados, o.parity_ok, o.erro_frame, o.cyc, e.dados, e.parity_ok, e.erro_frame, e.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_break();
        ev_t o, e;
        send_frame(8'h01, 1'b1, 1'b0, 40, 1'b0);
        n_checks++;
        if (db_estado !== 4'd6) begin n_fail++; $display("FAIL break_estado: got %0d want 6", db_estado); end
        RX = 1'b1;
        repeat (6) @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd0) begin n_fail++; $display("FAIL break_recover: got %0d want 0", db_estado); end
        n_checks++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL break_count: got %0d pulses want 1", obs_q.size()); end
        send_frame(8'h55, 1'b0, 1'b1, 1, 1'b1);
        repeat (2 * C) @(negedge clock);
        n_checks++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL break_after_count: got %0d pulses want 2", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL break_frame: got d=%h ok=%b err=%b cyc=%0d want d=%h ok=%b err=%b cyc=%0d", o.dados, o.parity_ok, o.erro_frame, o.cyc, e.dados, e.parity_ok, e.erro_frame, e.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch();
        bit occ_seen = 1'b0;
        RX = 1'b0;
        repeat (5) @(negedge clock);
        RX = 1'b1;
        repeat (3 * C) begin
            @(negedge clock);
            if (ocupado) occ_seen = 1'b1;
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_count: got %0d pulses want 0", obs_q.size()); end
        n_checks++;
        if (occ_seen) begin n_fail++; $display("FAIL glitch_ocupado: got 1 want 0"); end
        n_checks++;
        if (db_estado !== 4'd0 || dados !== 8'h55) begin n_fail++; $display("FAIL glitch_state: got estado=%0d d=%h want estado=0 d=55", db_estado, dados); end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        ev_t o, e;
        send_frame(8'h34, 1'b1, 1'b1, 1, 1'b1);
        send_frame(8'h12, 1'b0, 1'b1, 1, 1'b1);
        repeat (2 * C) @(negedge clock);
        n_checks++;
        if (obs_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d pulses want 2", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_frame: got d=%h ok=%b err=%b cyc=%0d want d=%h ok=%b err=%b cyc=%0d", o.dados, o.parity_ok, o.erro_frame, o.cyc, e.dados, e.parity_ok, e.erro_frame, e.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        ev_t o, e;
        logic [7:0] d = 8'hC3;
        drive_bits(1'b0, 1);
        for (int i = 0; i < 4; i++) drive_bits(d[i], 1);
        RX = d[4];
        repeat (HALF) @(negedge clock);
        n_checks++;
        if (ocupado !== 1'b1) begin n_fail++; $display("FAIL mid_ocupado: got %b want 1", ocupado); end
        reset = 1'b1;
        RX    = 1'b1;
        @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd0 || dados !== 8'h00 || fim_receber !== 1'b0 || ocupado !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got estado=%0d d=%h fim=%b occ=%b want 0 00 0 0", db_estado, dados, fim_receber, ocupado);
        end
        reset = 1'b0;
        repeat (2 * C) @(negedge clock);
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL mid_nopulse: got %0d pulses want 0", obs_q.size()); end
        send_frame(8'hFF, 1'b0, 1'b1, 1, 1'b1);
        repeat (2 * C) @(negedge clock);
        n_checks++;
        if (obs_q.size() != 1) begin n_fail++; $display("FAIL mid_after_count: got %0d pulses want 1", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL mid_frame: got d=%h ok=%b err=%b cyc=%0d want d=%h ok=%b err=%b cyc=%0d", o.dados, o.parity_ok, o.erro_frame, o.cyc, e.dados, e.parity_ok, e.erro_frame, e.cyc); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        RX    = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        test_reset();
        test_even_parity();
        test_bad_parity();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        n_checks++;
        if (double_fim != 0) begin n_fail++; $display("FAIL fim_single_cycle: got %0d double pulses want 0", double_fim); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
